// File: rtl/sa_job_ctrl.sv
// Job sequencer for the memA/memB + systolic array datapath: loads one DIM x DIM job,
// runs the skewed compute window, streams the C rows out, then zeroes the accumulators.
module sa_job_ctrl #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ROWBITS = $clog2(DIM)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DIM-1:0][BITS_AB-1:0]      a_row_in,
    input  logic [DIM-1:0][BITS_AB-1:0]      b_row_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DIM-1:0][BITS_C-1:0]       c_row_out,
    output logic [ROWBITS-1:0]               c_row_idx,
    output logic                             c_last,
    output logic                             busy,
    output logic                             en,
    output logic                             WrEnMemA,
    output logic [ROWBITS-1:0]               Arow,
    output logic [DIM-1:0][BITS_AB-1:0]      Ain,
    output logic [DIM-1:0][BITS_AB-1:0]      Bin,
    output logic                             WrEn,
    output logic [ROWBITS-1:0]               Crow,
    output logic [DIM-1:0][BITS_C-1:0]       Cin,
    input  logic [DIM-1:0][BITS_C-1:0]       Cout
);

    localparam int CNTBITS = $clog2(2 * DIM);

    typedef enum logic [2:0] {
        LOAD,
        COMPUTE,
        DRAIN_WAIT,
        DRAIN_OUT,
        CLEAR
    } state_t;

    state_t               state;
    logic [ROWBITS-1:0]   ld_cnt;
    logic [CNTBITS-1:0]   cnt;
    logic [ROWBITS-1:0]   r;
    logic                 beat;

    assign beat = (state == LOAD) && in_valid;

    // NOTE: every state register uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            ld_cnt    <= '0;
            cnt       <= '0;
            r         <= '0;
            out_valid <= 1'b0;
            c_row_out <= '0;
            c_row_idx <= '0;
            c_last    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (ld_cnt == ROWBITS'(DIM - 1)) begin
                            ld_cnt <= '0;
                            cnt    <= '0;
                            state  <= COMPUTE;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                end
                // Two DIM-long windows let the skewed operands fully traverse the array.
                COMPUTE: begin
                    if (cnt == CNTBITS'(2 * DIM - 1)) begin
                        r     <= '0;
                        state <= DRAIN_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN_WAIT: begin
                    c_row_out <= Cout;
                    c_row_idx <= r;
                    c_last    <= (r == ROWBITS'(DIM - 1));
                    out_valid <= 1'b1;
                    state     <= DRAIN_OUT;
                end
                DRAIN_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r == ROWBITS'(DIM - 1)) begin
                            cnt   <= '0;
                            state <= CLEAR;
                        end else begin
                            r     <= r + 1'b1;
                            state <= DRAIN_WAIT;
                        end
                    end
                end
                CLEAR: begin
                    if (cnt == CNTBITS'(DIM - 1)) begin
                        ld_cnt <= '0;
                        state  <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // NOTE: each output gets a default first so no path through the case infers a latch.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        en       = 1'b0;
        WrEnMemA = 1'b0;
        Arow     = '0;
        Ain      = '0;
        Bin      = '0;
        WrEn     = 1'b0;
        Crow     = '0;
        Cin      = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = (ld_cnt != '0);
                en       = beat;
                WrEnMemA = beat;
                Arow     = ld_cnt;
                if (beat) begin
                    Ain = a_row_in;
                    Bin = b_row_in;
                end
            end
            COMPUTE:    en   = 1'b1;
            DRAIN_WAIT: Crow = r;
            DRAIN_OUT:  Crow = r;
            CLEAR: begin
                WrEn = 1'b1;
                Crow = cnt[ROWBITS-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sa_job_ctrl.sv
// Bench for sa_job_ctrl: a behavioural memA/memB/array model feeds Cout, and a scoreboard
// of golden A*B rows (computed from the stimulus) is checked against the C row stream.
module tb_sa_job_ctrl;

    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 8;
    localparam int ROWBITS = 3;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         in_valid;
    logic                         in_ready;
    logic [DIM-1:0][BITS_AB-1:0]  a_row_in;
    logic [DIM-1:0][BITS_AB-1:0]  b_row_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [DIM-1:0][BITS_C-1:0]   c_row_out;
    logic [ROWBITS-1:0]           c_row_idx;
    logic                         c_last;
    logic                         busy;
    logic                         en;
    logic                         WrEnMemA;
    logic [ROWBITS-1:0]           Arow;
    logic [DIM-1:0][BITS_AB-1:0]  Ain;
    logic [DIM-1:0][BITS_AB-1:0]  Bin;
    logic                         WrEn;
    logic [ROWBITS-1:0]           Crow;
    logic [DIM-1:0][BITS_C-1:0]   Cin;
    logic [DIM-1:0][BITS_C-1:0]   Cout;

    sa_job_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM), .ROWBITS(ROWBITS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_row_in(a_row_in), .b_row_in(b_row_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .c_row_out(c_row_out), .c_row_idx(c_row_idx), .c_last(c_last),
        .busy(busy), .en(en), .WrEnMemA(WrEnMemA), .Arow(Arow),
        .Ain(Ain), .Bin(Bin), .WrEn(WrEn), .Crow(Crow), .Cin(Cin), .Cout(Cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- memA / memB / systolic array behavioural model ----------------
    logic signed [7:0] m_a [DIM][DIM];
    logic signed [7:0] m_b [DIM][DIM];
    logic [15:0]       m_c [DIM][DIM];
    int                en_only;

    function automatic logic [15:0] model_mac(int i, int j);
        int s = 0;
        for (int k = 0; k < DIM; k++) s += int'(m_a[i][k]) * int'(m_b[k][j]);
        return s[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    m_a[i][j] <= '0;
                    m_b[i][j] <= '0;
                    m_c[i][j] <= '0;
                end
            en_only <= 1000;
        end else begin
            if (WrEnMemA) begin
                for (int j = 0; j < DIM; j++) begin
                    m_a[Arow][j] <= Ain[j];
                    m_b[Arow][j] <= Bin[j];
                end
                en_only <= 0;
            end else if (en) begin
                if (en_only == 2 * DIM - 1)
                    for (int i = 0; i < DIM; i++)
                        for (int j = 0; j < DIM; j++)
                            m_c[i][j] <= m_c[i][j] + model_mac(i, j);
                en_only <= en_only + 1;
            end
            if (WrEn)
                for (int j = 0; j < DIM; j++) m_c[Crow][j] <= Cin[j];
        end
    end

    always_comb begin
        Cout = '0;
        for (int j = 0; j < DIM; j++) Cout[j] = m_c[Crow][j];
    end

    // ---------------- stimulus and scoreboard ----------------
    typedef struct {
        logic [ROWBITS-1:0]         idx;
        logic [DIM-1:0][BITS_C-1:0] data;
        logic                       last;
    } exp_t;

    exp_t sb[$];

    logic signed [7:0] ja [DIM][DIM];
    logic signed [7:0] jb [DIM][DIM];

    function automatic logic [15:0] gold(int i, int j);
        int s = 0;
        for (int k = 0; k < DIM; k++) s += int'(ja[i][k]) * int'(jb[k][j]);
        return s[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(int b);
        for (int j = 0; j < DIM; j++) begin
            a_row_in[j] = ja[b][j];
            b_row_in[j] = jb[b][j];
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ja[i][j] = 8'($urandom);
                jb[i][j] = 8'($urandom);
            end
    endtask

    // s2/s5: stall cycles after beats 2 and 5; bp_row/bp_len: consumer holds off that row.
    task automatic run_job(string name, int s2, int s5, int bp_row, int bp_len);
        int t0 = 0, t1 = 0, tend, en_cnt = 0, popped = 0, held = 0, budget = 0, clr_idx = 0;
        int stall;
        bit seen = 0;
        logic [DIM-1:0][BITS_C-1:0] hold_data = '0;
        exp_t e;

        for (int i = 0; i < DIM; i++) begin
            e.idx  = ROWBITS'(i);
            e.last = (i == DIM - 1);
            for (int j = 0; j < DIM; j++) e.data[j] = gold(i, j);
            sb.push_back(e);
        end

        for (int b = 0; b < DIM; b++) begin
            tick();
            in_valid = 1'b1;
            drive_row(b);
            if (b == 0) t0 = cyc;
            #1;
            if (en) en_cnt++;
            checks++;
            if (en !== 1'b1 || WrEnMemA !== 1'b1 || Arow !== ROWBITS'(b) || in_ready !== 1'b1 ||
                Ain !== a_row_in || Bin !== b_row_in) begin
                errors++;
                $display("FAIL %s load_beat%0d: en=%b wr=%b arow=%0d rdy=%b (required 1 1 %0d 1, Ain/Bin pass-through)",
                         name, b, en, WrEnMemA, Arow, in_ready, b);
            end
            stall = (b == 2) ? s2 : (b == 5) ? s5 : 0;
            for (int s = 0; s < stall; s++) begin
                tick();
                in_valid = 1'b0;
                #1;
                if (en) en_cnt++;
                checks++;
                if (en !== 1'b0 || WrEnMemA !== 1'b0 || Bin !== '0) begin
                    errors++;
                    $display("FAIL %s stall_en: en=%b wr=%b bin_nonzero=%b (required 0 0 0)",
                             name, en, WrEnMemA, Bin != '0);
                end
            end
        end

        // A beat offered during COMPUTE must be ignored.
        tick();
        in_valid = 1'b1;
        a_row_in = '1;
        b_row_in = '1;
        #1;
        if (en) en_cnt++;
        checks++;
        if (in_ready !== 1'b0 || WrEnMemA !== 1'b0 || en !== 1'b1 || Bin !== '0) begin
            errors++;
            $display("FAIL %s compute_ignores_in: rdy=%b wr=%b en=%b (required 0 0 1, Bin 0)",
                     name, in_ready, WrEnMemA, en);
        end
        in_valid = 1'b0;

        while (popped < DIM && budget < 300) begin
            tick();
            budget++;
            if (out_valid && !seen) begin
                seen = 1;
                t1   = cyc;
            end
            if (out_valid && int'(c_row_idx) == bp_row && held < bp_len) begin
                out_ready = 1'b0;
                if (held == 0) begin
                    hold_data = c_row_out;
                end else begin
                    checks++;
                    if (c_row_out !== hold_data || int'(c_row_idx) != bp_row) begin
                        errors++;
                        $display("FAIL %s bp_stable: idx=%0d data_changed=%b (required idx %0d, data held)",
                                 name, c_row_idx, c_row_out !== hold_data, bp_row);
                    end
                end
                held++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (en) en_cnt++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s sb_empty: extra row idx=%0d (required no further rows)", name, c_row_idx);
                end else begin
                    e = sb.pop_front();
                    if (c_row_out !== e.data || c_row_idx !== e.idx || c_last !== e.last) begin
                        errors++;
                        $display("FAIL %s row%0d: idx=%0d last=%b data=%h (required idx %0d last %b data %h)",
                                 name, e.idx, c_row_idx, c_last, c_row_out, e.idx, e.last, e.data);
                    end
                end
                popped++;
            end
        end
        checks++;
        if (popped != DIM) begin
            errors++;
            $display("FAIL %s drain_timeout: rows=%0d (required %0d)", name, popped, DIM);
        end

        budget = 0;
        while (busy && budget < 50) begin
            tick();
            budget++;
            out_ready = 1'b1;
            #1;
            if (en) en_cnt++;
            if (WrEn) begin
                checks++;
                if (Cin !== '0 || int'(Crow) != clr_idx) begin
                    errors++;
                    $display("FAIL %s clear_row: crow=%0d cin_nonzero=%b (required crow %0d, cin 0)",
                             name, Crow, Cin != '0, clr_idx);
                end
                clr_idx++;
            end
        end
        tend = cyc;

        checks++;
        if (clr_idx != DIM || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s clear_count: rows=%0d busy=%b (required %0d, 0)", name, clr_idx, busy, DIM);
        end
        checks++;
        if (!seen || t1 - t0 != 25 + s2 + s5) begin
            errors++;
            $display("FAIL %s first_out_latency: %0d (required %0d)", name, t1 - t0, 25 + s2 + s5);
        end
        checks++;
        if (tend - t0 != 48 + s2 + s5 + bp_len) begin
            errors++;
            $display("FAIL %s job_latency: %0d (required %0d)", name, tend - t0, 48 + s2 + s5 + bp_len);
        end
        checks++;
        if (en_cnt != 3 * DIM) begin
            errors++;
            $display("FAIL %s en_cycles: %0d (required %0d)", name, en_cnt, 3 * DIM);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_row_in  = '0;
        b_row_in  = '0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: rdy=%b busy=%b ov=%b (required 1 0 0)", in_ready, busy, out_valid);
        end
        checks++;
        if (en !== 1'b0 || WrEnMemA !== 1'b0 || WrEn !== 1'b0 || Crow !== '0 || Arow !== '0 ||
            c_row_out !== '0 || c_row_idx !== '0 || c_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b wr=%b wrc=%b crow=%0d arow=%0d last=%b (required all 0)",
                     en, WrEnMemA, WrEn, Crow, Arow, c_last);
        end
        rst = 1'b0;
    endtask

    task automatic set_identity_a();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) ja[i][j] = (i == j) ? 8'sd1 : 8'sd0;
    endtask

    task automatic test_identity();
        set_identity_a();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) jb[i][j] = 8'(i * 8 + j);
        run_job("identity", 0, 0, -1, 0);
    endtask

    task automatic test_load_stalls();
        fill_random();
        run_job("load_stalls", 3, 1, -1, 0);
    endtask

    task automatic test_backpressure();
        fill_random();
        run_job("backpressure", 0, 0, 3, 5);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ja[i][j] = -8'sd128;
                jb[i][j] = -8'sd128;
            end
        run_job("overflow_neg", 0, 0, -1, 0);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ja[i][j] = 8'sd1;
                jb[i][j] = 8'sd1;
            end
        run_job("overflow_ones", 0, 0, -1, 0);
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_job("b2b_first", 0, 0, -1, 0);
        set_identity_a();
        run_job("b2b_identity", 0, 0, -1, 0);
    endtask

    task automatic test_reset_mid();
        fill_random();
        for (int b = 0; b < DIM; b++) begin
            tick();
            in_valid = 1'b1;
            drive_row(b);
        end
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || WrEn !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b en=%b busy=%b ov=%b wrc=%b (required 1 0 0 0 0)",
                     in_ready, en, busy, out_valid, WrEn);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        fill_random();
        run_job("after_reset", 0, 0, -1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_load_stalls();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d rows (required 0)", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
